// File: rtl/dual_fetch_buffer_pkg.sv
// Shared types and constants for the dual-issue fetch buffer.
// Entry layout, pipe register masks and the ID counter helper.
package dual_fetch_buffer_pkg;

  localparam int ADDR_WIDTH           = 16;
  localparam int INST_WIDTH           = 32;
  localparam int INSTRUCTION_ID_WIDTH = 4;
  localparam int NUM_PIPE_MASKS       = 5;
  localparam int FETCH_BUFFER_DEPTH   = 8;

  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_PC     = 5'b00001;
  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_IF_ID  = 5'b00010;
  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_ID_EX  = 5'b00100;
  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_EX_MEM = 5'b01000;
  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_MEM_WB = 5'b10000;

  localparam logic [INST_WIDTH-1:0] NOP_INSTRUCTION = '0;

  typedef logic [ADDR_WIDTH-1:0]           addr_t;
  typedef logic [INST_WIDTH-1:0]           inst_t;
  typedef logic [INSTRUCTION_ID_WIDTH-1:0] id_t;
  typedef logic [NUM_PIPE_MASKS-1:0]       mask_t;

  typedef struct packed {
    inst_t inst;
    addr_t pc;
    id_t   id;
  } fb_entry_t;

  // ID 0 marks a NOP, so the counter steps over it on wrap.
  function automatic id_t id_inc(id_t x);
    id_t n;
    n = x + id_t'(1);
    return (n == '0) ? id_t'(1) : n;
  endfunction

endpackage

// File: rtl/dual_fetch_buffer_if.sv
// Fetch buffer bus: instruction memory side, hazard masks,
// branch redirect and the two issue slots.
interface dual_fetch_buffer_if #(
    parameter int PTR_BITS = 3
);
  import dual_fetch_buffer_pkg::*;

  addr_t             imem_addr;
  inst_t             imem_instruction0;
  inst_t             imem_instruction1;
  mask_t             stall0;
  mask_t             stall1;
  mask_t             flush0;
  mask_t             flush1;
  logic              branch_taken;
  addr_t             branch_target;
  inst_t             instruction0_out;
  inst_t             instruction1_out;
  addr_t             pc0_out;
  addr_t             pc1_out;
  id_t               id0_out;
  id_t               id1_out;
  logic              first;
  logic [PTR_BITS:0] count;

  modport master (
    output imem_addr,
    input  imem_instruction0, imem_instruction1,
    input  stall0, stall1, flush0, flush1,
    input  branch_taken, branch_target,
    output instruction0_out, instruction1_out,
    output pc0_out, pc1_out, id0_out, id1_out,
    output first, count
  );

  modport slave (
    input  imem_addr,
    output imem_instruction0, imem_instruction1,
    output stall0, stall1, flush0, flush1,
    output branch_taken, branch_target,
    input  instruction0_out, instruction1_out,
    input  pc0_out, pc1_out, id0_out, id1_out,
    input  first, count
  );

endinterface

// File: rtl/dual_fetch_buffer_entry_ram.sv
// Two-write / two-read entry array for the fetch buffer.
// Data is not reset; validity is tracked by the pointers.
module fetch_entry_ram
  import dual_fetch_buffer_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PTR_BITS = 3
) (
    input  logic                clk,
    input  logic                we,
    input  logic [PTR_BITS-1:0] waddr,
    input  fb_entry_t           wdata0,
    input  fb_entry_t           wdata1,
    input  logic [PTR_BITS-1:0] raddr0,
    input  logic [PTR_BITS-1:0] raddr1,
    output fb_entry_t           rdata0,
    output fb_entry_t           rdata1
);

  fb_entry_t mem [DEPTH];
  logic [PTR_BITS-1:0] waddr1;

  assign waddr1 = waddr + 1'b1;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr]  <= wdata0;
      mem[waddr1] <= wdata1;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/dual_fetch_buffer.sv
// Dual-issue fetch front end: owns the fetch PC, tags pairs
// with PC/ID and queues them for the two issue slots.
module dual_fetch_buffer
  import dual_fetch_buffer_pkg::*;
#(
    parameter int DEPTH    = FETCH_BUFFER_DEPTH,
    parameter int PTR_BITS = 3
) (
    input logic                clk,
    input logic                reset,
    dual_fetch_buffer_if.master bus
);

  typedef logic [PTR_BITS:0] ptr_t;

  addr_t     fetch_pc;
  ptr_t      head;
  ptr_t      tail;
  id_t       next_id;
  id_t       id_b;
  ptr_t      cnt;
  ptr_t      deq;
  ptr_t      occ_after;
  logic [1:0] deq_req;
  logic      ld0;
  logic      ld1;
  logic      enq;
  fb_entry_t wdata0;
  fb_entry_t wdata1;
  fb_entry_t e_head;
  fb_entry_t e_next;
  fb_entry_t v_head;
  fb_entry_t v_next;
  fb_entry_t slot0;
  fb_entry_t slot1;

  assign cnt = tail - head;
  assign ld0 = |(bus.stall0 & PIPE_REG_IF_ID);
  assign ld1 = |(bus.stall1 & PIPE_REG_IF_ID);

  always_comb begin
    deq_req = 2'd2;
    unique case (1'b1)
      ld0 && ld1: deq_req = 2'd0;
      ld0 ^ ld1:  deq_req = 2'd1;
      default:    deq_req = 2'd2;
    endcase
  end

  assign deq = (cnt < ptr_t'(deq_req)) ? cnt : ptr_t'(deq_req);
  assign occ_after = cnt - deq;
  // Enqueue only when both new entries fit after this cycle's dequeue.
  assign enq = !bus.branch_taken &&
               (occ_after <= ptr_t'(DEPTH - 2));

  assign id_b   = id_inc(next_id);
  assign wdata0 = '{inst: bus.imem_instruction0,
                    pc: fetch_pc, id: next_id};
  assign wdata1 = '{inst: bus.imem_instruction1,
                    pc: fetch_pc + addr_t'(1), id: id_b};

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= '0;
      head     <= '0;
      tail     <= '0;
      next_id  <= id_t'(1);
    end else if (bus.branch_taken) begin
      head     <= tail;
      fetch_pc <= bus.branch_target;
    end else begin
      head <= head + deq;
      if (enq) begin
        tail     <= tail + ptr_t'(2);
        fetch_pc <= fetch_pc + addr_t'(2);
        next_id  <= id_inc(id_b);
      end
    end
  end

  fetch_entry_ram #(
    .DEPTH    (DEPTH),
    .PTR_BITS (PTR_BITS)
  ) u_ram (
    .clk    (clk),
    .we     (enq && !reset),
    .waddr  (tail[PTR_BITS-1:0]),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .raddr0 (head[PTR_BITS-1:0]),
    .raddr1 (head[PTR_BITS-1:0] + 1'b1),
    .rdata0 (e_head),
    .rdata1 (e_next)
  );

  assign v_head = (cnt != '0) ? e_head : '0;
  assign v_next = (cnt >= ptr_t'(2)) ? e_next : '0;
  // Entries sit in slot = index parity, so a split stall leaves
  // the younger instruction in place and just flips first.
  assign slot0 = head[0] ? v_next : v_head;
  assign slot1 = head[0] ? v_head : v_next;

  assign bus.imem_addr        = fetch_pc;
  assign bus.instruction0_out = slot0.inst;
  assign bus.instruction1_out = slot1.inst;
  assign bus.pc0_out          = slot0.pc;
  assign bus.pc1_out          = slot1.pc;
  assign bus.id0_out          = slot0.id;
  assign bus.id1_out          = slot1.id;
  assign bus.first            = ~head[0];
  assign bus.count            = cnt;

endmodule

// File: doc/dual_fetch_buffer.md
Name: dual_fetch_buffer

Overview:
- Front end of the dual-issue pipeline. Owns the fetch PC and reads two sequential instructions per cycle from instruction memory.
- Tags each fetched instruction with its PC and a unique instruction ID, then holds it in a small in-order FIFO.
- Presents the oldest two entries to the IF/ID registers and hazard detection unit as slot 0/1, plus the `first` ordering bit.
- Consumes 0, 1 or 2 entries per cycle, as directed by the hazard unit's stall/flush masks. Branch resolution redirects the fetch PC.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 4.
- PTR_BITS, 3, log2(DEPTH).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- imem_addr  out  `ADDR_WIDTH`  word address of fetch pair; instruction memory returns the pair combinationally the same cycle
- imem_instruction0  in  `INST_WIDTH`  instruction at imem_addr
- imem_instruction1  in  `INST_WIDTH`  instruction at imem_addr+1
- stall0  in  `NUM_PIPE_MASKS`  pipe 0 stall mask from hazard unit
- stall1  in  `NUM_PIPE_MASKS`  pipe 1 stall mask
- flush0  in  `NUM_PIPE_MASKS`  pipe 0 flush mask
- flush1  in  `NUM_PIPE_MASKS`  pipe 1 flush mask
- branch_taken  in  1  resolved taken branch / jump
- branch_target  in  `ADDR_WIDTH`  redirect address
- instruction0_out  out  `INST_WIDTH`  slot 0 instruction
- instruction1_out  out  `INST_WIDTH`  slot 1 instruction
- pc0_out  out  `ADDR_WIDTH`  slot 0 PC
- pc1_out  out  `ADDR_WIDTH`  slot 1 PC
- id0_out  out  `INSTRUCTION_ID_WIDTH`  slot 0 ID
- id1_out  out  `INSTRUCTION_ID_WIDTH`  slot 1 ID
- first  out  1  1 = slot 0 holds the older instruction
- count  out  PTR_BITS+1  occupied entries (debug/verification)

Behaviour:
- State:
  - fetch_pc
  - head and tail pointers, PTR_BITS+1 bits each; wrap via the extra MSB
  - next_id
  - entry arrays holding {instruction, pc, id}
- Reset (synchronous): fetch_pc=0, head=tail=0, next_id=1, first=1; all slot outputs 0 (NOP, pc 0, id 0).
- Fetch/enqueue:
  - imem_addr = fetch_pc.
  - When free entries after this cycle's dequeue ≥2 and branch_taken=0: write both instructions at tail and tail+1, with pc fetch_pc and fetch_pc+1 and ids next_id and next_id+1.
  - Then tail+=2, fetch_pc+=2, next_id+=2.
  - Otherwise nothing is written and fetch_pc holds.
- ID rule: the ID counter wraps modulo 2^`INSTRUCTION_ID_WIDTH` and skips 0; 0 is reserved for NOP.
- Presentation (combinational from registered state):
  - The head entry maps to slot (head[0]).
  - Slot 0 shows entry at the even index of {head, head+1}; slot 1 shows the odd one.
  - first = ~head[0].
  - A slot whose entry is not valid (count <2, or count=0) shows instruction 0, pc 0, id 0.
- Dequeue count, derived each cycle from the masks:
  - 0 if both stall masks contain `PIPE_REG_IF_ID` (load stall).
  - 1 if exactly one pipe's stall mask contains `PIPE_REG_IF_ID` (split stall). The older instruction is consumed; the younger stays in its slot and first toggles.
  - 2 otherwise.
  - The dequeue count is clamped to count.
- Redirect: branch_taken=1 gives, next cycle, head=tail (empty), fetch_pc=branch_target, and no enqueue this cycle.
  - branch_taken overrides any stall or dequeue the same cycle.
  - next_id is not rewound.
- Full: with count > DEPTH-2 after dequeue, fetch pauses; no entry is ever overwritten.
- Empty: both slots are NOP; the masks are ignored.
- Latency: an instruction fetched in cycle N is visible on the slot outputs in cycle N+1.
- Reset asserted mid-operation discards all entries the same edge.

Decomposition:
- Shared defines header gets:
  - `NOP_INSTRUCTION`
  - `PIPE_REG_IF_ID` (already exists)
  - `FETCH_BUFFER_DEPTH` default
- One sub-module is natural: fetch_entry_ram, a DEPTH×(INST+ADDR+ID) two-write/two-read register array with no reset on data.

Test Plan:
- Reset, imem holds sequential nonzero instructions at 0..15, no stalls, no branch:
  - Cycle 1 shows pc0=0, pc1=1, id 1/2, first=1.
  - Pairs then advance by 2 each cycle.
- Hold both stall masks = `PIPE_REG_PC|PIPE_REG_IF_ID` for 5 cycles:
  - Outputs are frozen.
  - count reaches 8 and fetch_pc stops, with no overwrite.
  - After release the sequence resumes at the next PCs without gaps.
- Split stall: stall0 has IF_ID and stall1 has PC only, with first=1 and slot pcs 4/5:
  - Next cycle slot1 still pc 5, slot0 becomes pc 6, first=0.
- branch_taken=1 with target 0x20, asserted during a load stall:
  - Next cycle both slots are NOP.
  - The cycle after shows pc 0x20/0x21, first=1, ids continuing from the previous count.
- ID wrap: run until next_id reaches 2^W−1:
  - The following ids are 2^W−1, then 1; id 0 is never issued.
- Assert reset with 6 entries queued:
  - Next cycle count=0, slot outputs 0, imem_addr=0.
